// File: rtl/tpp_pkg.sv
// Shared definitions for the TPP stage: instruction opcodes, FSM state
// encoding, and the bit layout of the 32-bit instruction slot.
package tpp_pkg;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,  // beats before the instruction beat
    ST_INS  = 2'd1,  // instruction beat is at the FIFO head
    ST_EXEC = 2'd2,  // hop-memory beat is at the FIFO head, instruction pending
    ST_PASS = 2'd3   // rest of the packet flows through untouched
  } tpp_state_e;

  typedef enum logic [7:0] {
    OP_LOAD  = 8'd0,
    OP_STORE = 8'd2,
    OP_CAS   = 8'd4
  } tpp_opcode_e;

  // Instruction slot layout: {imm[15:0], addr[7:0], opcode[7:0]}
  localparam int INS_SLOT_WIDTH = 32;
  localparam int OPCODE_LSB     = 0;
  localparam int OPCODE_WIDTH   = 8;
  localparam int ADDR_LSB       = 8;
  localparam int ADDR_WIDTH     = 8;
  localparam int IMM_LSB        = 16;
  localparam int IMM_WIDTH      = 16;

  localparam int BEAT_CNT_WIDTH = 8;

  // Only these opcodes need the hop-memory beat; anything else skips to PASS.
  function automatic logic is_exec_opcode(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_CAS);
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: the head entry is always presented on
// dout while the FIFO is non-empty, so a word written in cycle N appears in
// cycle N+1. nearly_full asserts one entry before full.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      do_wr;
  logic                      do_rd;

  assign do_wr       = wr_en && (count != (MAX_DEPTH_BITS+1)'(DEPTH));
  assign do_rd       = rd_en && !empty;
  assign empty       = (count == '0);
  assign nearly_full = (count >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));
  assign dout        = mem[rd_ptr];

  // Storage array write port.
  // NOTE: the data array is deliberately not reset; only the pointers and
  // count define validity, and leaving the array out of reset keeps it plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // design samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tpp_v2.sv
// TPP stage: buffers an AXI4-Stream packet and executes one tiny-packet-program
// instruction (LOAD / STORE / CAS) against a local register file, patching the
// hop-memory slot of the beat that follows the instruction beat.
module tpp_v2
  import tpp_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = C_M_AXIS_DATA_WIDTH,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = C_M_AXIS_TUSER_WIDTH,
  parameter int NUM_REGS             = 8,
  parameter int REG_WIDTH            = 64,
  parameter int TPP_STAGE            = 0,
  parameter int INS_BEAT             = 2,
  parameter int FIFO_DEPTH_BITS      = 2,
  parameter logic [NUM_REGS-1:0]           REG_WRITE_PERMISSION = {NUM_REGS{1'b1}},
  parameter logic [NUM_REGS*REG_WIDTH-1:0] REG_DEFAULT          = '0
) (
  input  logic                                axi_aclk,
  input  logic                                axi_reset,

  input  logic [NUM_REGS*REG_WIDTH-1:0]       tpp_regs_in,
  output logic [NUM_REGS*REG_WIDTH-1:0]       tpp_regs_out,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  output logic                                s_axis_tready,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,

  output logic [31:0]                         cas_fail_count
);

  localparam int STRB_WIDTH = C_S_AXIS_DATA_WIDTH / 8;
  localparam int FIFO_WIDTH = C_S_AXIS_DATA_WIDTH + STRB_WIDTH + C_S_AXIS_TUSER_WIDTH + 1;
  localparam int REG_AW     = $clog2(NUM_REGS);
  localparam int INS_LSB    = TPP_STAGE * INS_SLOT_WIDTH;
  localparam int HOP_LSB    = TPP_STAGE * REG_WIDTH;
  // With the instruction on beat 0 there are no header beats to skip.
  localparam tpp_state_e FIRST_STATE = (INS_BEAT == 0) ? ST_INS : ST_HDR;

  // ---------------------------------------------------------------- input FIFO
  logic [FIFO_WIDTH-1:0]           fifo_din;
  logic [FIFO_WIDTH-1:0]           fifo_dout;
  logic                            fifo_empty;
  logic                            fifo_nearly_full;
  logic                            fifo_wr;
  logic                            handshake;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  in_data;
  logic [STRB_WIDTH-1:0]           in_strb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] in_user;
  logic                            in_last;

  assign fifo_din      = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
  assign s_axis_tready = !fifo_nearly_full && !axi_reset;
  assign fifo_wr       = s_axis_tvalid && s_axis_tready;

  fallthrough_small_fifo #(
    .WIDTH          (FIFO_WIDTH),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_in_fifo (
    .clk         (axi_aclk),
    .reset       (axi_reset),
    .din         (fifo_din),
    .wr_en       (fifo_wr),
    .rd_en       (handshake),
    .dout        (fifo_dout),
    .nearly_full (fifo_nearly_full),
    .empty       (fifo_empty)
  );

  assign {in_last, in_user, in_strb, in_data} = fifo_dout;

  assign m_axis_tvalid = !fifo_empty && !axi_reset;
  assign handshake     = m_axis_tvalid && m_axis_tready;
  assign m_axis_tstrb  = in_strb;
  assign m_axis_tuser  = in_user;
  assign m_axis_tlast  = in_last;

  // ---------------------------------------------------------------- state
  tpp_state_e                 state_q, state_d;
  logic [BEAT_CNT_WIDTH-1:0]  beat_q;
  logic [OPCODE_WIDTH-1:0]    opcode_q;
  logic [REG_AW-1:0]          addr_q;
  logic [IMM_WIDTH-1:0]       imm_q;
  logic [REG_WIDTH-1:0]       regs_q [NUM_REGS];

  logic [REG_WIDTH-1:0]       hop_slot;
  logic [REG_WIDTH-1:0]       cur_reg;
  logic                       cas_match;
  logic                       reg_we;
  logic                       cas_fail;
  logic [C_M_AXIS_DATA_WIDTH-1:0] out_data;

  assign hop_slot  = in_data[HOP_LSB +: REG_WIDTH];
  assign cur_reg   = regs_q[addr_q];
  assign cas_match = (cur_reg[IMM_WIDTH-1:0] == imm_q);

  // Instruction execution: patch the hop slot and raise write/fail strobes.
  // Strobes are qualified by the handshake so a stalled beat has no side effect.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    out_data = in_data;
    reg_we   = 1'b0;
    cas_fail = 1'b0;
    if (state_q == ST_EXEC) begin
      case (opcode_q)
        OP_LOAD:  out_data[HOP_LSB +: REG_WIDTH] = cur_reg;
        OP_STORE: reg_we = handshake;
        OP_CAS: begin
          if (cas_match) begin
            out_data[HOP_LSB +: REG_WIDTH] = cur_reg;
            reg_we = handshake;
          end else begin
            cas_fail = handshake;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axis_tdata = out_data;

  // Next-state logic: advances only on an output handshake; tlast always restarts.
  always_comb begin
    state_d = state_q;
    if (handshake) begin
      if (in_last) begin
        state_d = FIRST_STATE;
      end else begin
        case (state_q)
          ST_HDR:  if (beat_q == BEAT_CNT_WIDTH'(INS_BEAT - 1)) state_d = ST_INS;
          ST_INS:  state_d = is_exec_opcode(in_data[INS_LSB + OPCODE_LSB +: OPCODE_WIDTH])
                             ? ST_EXEC : ST_PASS;
          ST_EXEC: state_d = ST_PASS;
          default: ;
        endcase
      end
    end
  end

  // State register, saturating beat counter and latched instruction fields.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q  <= FIRST_STATE;
      beat_q   <= '0;
      opcode_q <= '0;
      addr_q   <= '0;
      imm_q    <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        if (in_last)                beat_q <= '0;
        else if (beat_q != '1)      beat_q <= beat_q + 1'b1;
      end
      if (handshake && state_q == ST_INS) begin
        opcode_q <= in_data[INS_LSB + OPCODE_LSB +: OPCODE_WIDTH];
        addr_q   <= in_data[INS_LSB + ADDR_LSB   +: REG_AW];
        imm_q    <= in_data[INS_LSB + IMM_LSB    +: IMM_WIDTH];
      end
    end
  end

  // Register file: read-only registers mirror tpp_regs_in; writable ones take
  // STORE/CAS results.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_DEFAULT[i*REG_WIDTH +: REG_WIDTH];
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (!REG_WRITE_PERMISSION[i])
          regs_q[i] <= tpp_regs_in[i*REG_WIDTH +: REG_WIDTH];
        else if (reg_we && addr_q == REG_AW'(i))
          regs_q[i] <= hop_slot;
      end
    end
  end

  // Failed compare-and-swap counter, wraps naturally at 2^32.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset)     cas_fail_count <= '0;
    else if (cas_fail) cas_fail_count <= cas_fail_count + 32'd1;
  end

  // Flatten the register file onto the output bus.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) tpp_regs_out[i*REG_WIDTH +: REG_WIDTH] = regs_q[i];
  end

  // tpp_regs_in is only consumed for read-only registers; fold the rest here.
  logic unused_regs_in;
  assign unused_regs_in = ^tpp_regs_in;

endmodule

// File: tb/tb_tpp_v2.sv
// Scoreboard bench for tpp_v2: stimulus pushes expected output beats into a
// queue, an independent monitor pops and compares on every output handshake.
module tb_tpp_v2;

  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam int UW = 128;
  localparam int NR = 8;
  localparam int RW = 64;

  localparam logic [NR-1:0]    PERM    = 8'b1111_1011;  // reg2 read-only
  localparam logic [NR*RW-1:0] REG_DEF = {64'h0, 64'h0, 64'h0, 64'h0,
                                          64'h1122334455667788, 64'h0,
                                          64'h0123456789AB00AA, 64'h0};

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            axi_reset;
  logic [NR*RW-1:0] tpp_regs_in;
  logic [NR*RW-1:0] tpp_regs_out;
  logic [DW-1:0]   s_axis_tdata;
  logic [SW-1:0]   s_axis_tstrb;
  logic [UW-1:0]   s_axis_tuser;
  logic            s_axis_tvalid;
  logic            s_axis_tlast;
  logic            s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic [SW-1:0]   m_axis_tstrb;
  logic [UW-1:0]   m_axis_tuser;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic            m_axis_tready;
  logic [31:0]     cas_fail_count;

  int    checks = 0;
  int    errors = 0;
  int    rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready
  beat_t sb[$];

  always #5 clk = ~clk;

  tpp_v2 #(
    .NUM_REGS             (NR),
    .REG_WIDTH            (RW),
    .REG_WRITE_PERMISSION (PERM),
    .REG_DEFAULT          (REG_DEF)
  ) dut (
    .axi_aclk       (clk),
    .axi_reset      (axi_reset),
    .tpp_regs_in    (tpp_regs_in),
    .tpp_regs_out   (tpp_regs_out),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tstrb   (s_axis_tstrb),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tstrb   (m_axis_tstrb),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .cas_fail_count (cas_fail_count)
  );

  task automatic check(input string name, input logic [NR*RW-1:0] act, input logic [NR*RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] reg_out(input int i);
    return tpp_regs_out[i*RW +: RW];
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    for (int w = 0; w < DW/32; w++) b.data[w*32 +: 32] = $urandom;
    b.strb = $urandom;
    for (int w = 0; w < UW/32; w++) b.user[w*32 +: 32] = $urandom;
    b.last = 1'b0;
    return b;
  endfunction

  // Output-side ready generator.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Monitor: the values seen here are what the next rising edge transfers.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #1;
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", m_axis_tvalid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("out_tdata", m_axis_tdata, e.data);
          check("out_tstrb", m_axis_tstrb, e.strb);
          check("out_tuser", m_axis_tuser, e.user);
          check("out_tlast", m_axis_tlast, e.last);
        end
      end
    end
  end

  task automatic send_beat(input beat_t b);
    int waited = 0;
    @(negedge clk);
    s_axis_tdata  = b.data;
    s_axis_tstrb  = b.strb;
    s_axis_tuser  = b.user;
    s_axis_tlast  = b.last;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!s_axis_tready) check("s_tready_timeout", s_axis_tready, 1'b1);
    else @(posedge clk);
  endtask

  // Sends a packet; when 'modify' is set the hop slot of beat 3 is expected
  // to come out as exp_hop, every other bit of every beat unchanged.
  task automatic send_packet(input int len, input logic [31:0] ins, input logic [RW-1:0] hop,
                             input logic [RW-1:0] exp_hop, input bit modify);
    beat_t b, e;
    for (int i = 0; i < len; i++) begin
      b = rand_beat();
      if (i == 2) b.data[31:0] = ins;
      if (i == 3) b.data[RW-1:0] = hop;
      b.last = (i == len - 1);
      e = b;
      if (modify && i == 3) e.data[RW-1:0] = exp_hop;
      sb.push_back(e);
      send_beat(b);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    logic [RW-1:0] last_r6;
    int len;
    bit exec;
    logic [31:0] ins;
    logic [RW-1:0] hop;
    logic [RW-1:0] exp_hop;
    bit modify;
    beat_t b;

    for (int i = 0; i < NR; i++) tpp_regs_in[i*RW +: RW] = 64'hA5A5_0000_0000_0000 | 64'(i);
    axi_reset     = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    rdy_mode      = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_regs", tpp_regs_out, REG_DEF);
    check("rst_cas_cnt", cas_fail_count, 32'd0);
    axi_reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reg2_follows_in", reg_out(2), 64'hA5A5_0000_0000_0002);

    // LOAD reg3 into the hop slot
    send_packet(5, 32'h0000_0300, 64'h0BAD_F00D_0000_0000, 64'h1122334455667788, 1);
    drain();

    // STORE hop slot into reg5
    send_packet(5, 32'h0000_0502, 64'hDEADBEEF00000001, 64'h0, 0);
    drain();
    check("store_reg5", reg_out(5), 64'hDEADBEEF00000001);
    check("store_reg3_kept", reg_out(3), 64'h1122334455667788);

    // CAS on reg1, matching immediate: swap
    send_packet(4, 32'h00AA_0104, 64'hCAFE000000001234, 64'h0123456789AB00AA, 1);
    drain();
    check("cas_ok_reg1", reg_out(1), 64'hCAFE000000001234);
    check("cas_ok_cnt", cas_fail_count, 32'd0);

    // CAS on reg1, mismatching immediate: no change, count once
    send_packet(4, 32'h00AB_0104, 64'h7777_7777_7777_7777, 64'h0, 0);
    drain();
    check("cas_fail_reg1", reg_out(1), 64'hCAFE000000001234);
    check("cas_fail_cnt", cas_fail_count, 32'd1);

    // Read-only reg2: STORE ignored, CAS returns current value without writing
    send_packet(4, 32'h0000_0202, 64'h5555_5555_5555_5555, 64'h0, 0);
    drain();
    check("ro_store_reg2", reg_out(2), 64'hA5A5_0000_0000_0002);
    send_packet(4, 32'h0002_0204, 64'h9999_9999_9999_9999, 64'hA5A5_0000_0000_0002, 1);
    drain();
    check("ro_cas_reg2", reg_out(2), 64'hA5A5_0000_0000_0002);
    check("ro_cas_cnt", cas_fail_count, 32'd1);

    // tlast on the instruction beat executes nothing, next packet is clean
    send_packet(3, 32'h0000_0300, 64'h0, 64'h0, 0);
    send_packet(4, 32'h0000_0007, 64'h4444_4444_4444_4444, 64'h0, 0);
    send_packet(2, 32'h0000_0000, 64'h0, 64'h0, 0);
    send_packet(1, 32'h0000_0000, 64'h0, 64'h0, 0);
    drain();
    check("short_cnt", cas_fail_count, 32'd1);

    // Backpressure: 100 packets of mixed lengths and opcodes, random ready
    rdy_mode = 1;
    exp_cnt  = 1;
    last_r6  = 64'h0;
    for (int k = 0; k < 100; k++) begin
      len     = 1 + ((k * 3) % 7);
      exec    = (len >= 4);
      hop     = {32'($urandom), 32'($urandom)};
      exp_hop = hop;
      modify  = 1'b0;
      case (k % 4)
        0: begin ins = 32'h0000_0300; exp_hop = 64'h1122334455667788; modify = exec; end
        1: begin ins = 32'hFFFF_0104; if (exec) exp_cnt++; end
        2: begin ins = 32'h0000_0602; hop = {32'h600D_0000, 32'(k)}; if (exec) last_r6 = hop; end
        default: ins = 32'h0000_0007;
      endcase
      send_packet(len, ins, hop, exp_hop, modify);
    end
    rdy_mode = 0;
    drain();
    check("bp_cas_cnt", cas_fail_count, 32'(exp_cnt));
    check("bp_reg6", reg_out(6), last_r6);
    check("bp_reg1", reg_out(1), 64'hCAFE000000001234);
    check("bp_reg3", reg_out(3), 64'h1122334455667788);

    // Reset while beats 0..1 are buffered and beat 2 is being offered
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    send_beat(rand_beat());
    send_beat(rand_beat());
    @(negedge clk);
    b = rand_beat();
    s_axis_tdata  = b.data;
    s_axis_tvalid = 1'b1;
    axi_reset     = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    check("mid_rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("mid_rst_regs", tpp_regs_out, REG_DEF);
    check("mid_rst_cnt", cas_fail_count, 32'd0);
    @(negedge clk);
    axi_reset = 1'b0;
    rdy_mode  = 0;
    repeat (3) @(negedge clk);
    check("post_rst_flushed", m_axis_tvalid, 1'b0);
    send_packet(5, 32'h0000_0100, 64'h1234_0000_0000_4321, 64'h0123456789AB00AA, 1);
    drain();
    check("post_rst_cnt", cas_fail_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpp_v2.md
TPP_V2 -- requirements
Module: tpp_v2

Interface
REQ-001 SHALL: one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter C_M_AXIS_DATA_WIDTH, 256, master tdata width; C_S_AXIS_DATA_WIDTH equal, 256.
REQ-003 SHALL have parameter C_M_AXIS_TUSER_WIDTH, 128, tuser width; C_S_AXIS_TUSER_WIDTH equal, 128.
REQ-004 SHALL have parameter NUM_REGS, 8, register count (power of 2, 2..64).
REQ-005 SHALL have parameter REG_WIDTH, 64, register and hop-memory slot width.
REQ-006 SHALL have parameter TPP_STAGE, 0, slot index (32-bit instruction slot, REG_WIDTH hop-memory slot).
REQ-007 SHALL have parameter INS_BEAT, 2, zero-based beat carrying instructions; hop memory is beat INS_BEAT+1.
REQ-008 SHALL have parameter FIFO_DEPTH_BITS, 2, log2 input FIFO depth.
REQ-009 SHALL have parameter REG_WRITE_PERMISSION, all ones, NUM_REGS bits; bit 0 makes register follow tpp_regs_in.
REQ-010 SHALL have parameter REG_DEFAULT, 0, NUM_REGS*REG_WIDTH flattened reset values.
REQ-011 SHALL have ports: axi_aclk in 1 clock; axi_reset in 1 sync active-high reset.
REQ-012 SHALL have ports: tpp_regs_in in NUM_REGS*REG_WIDTH external values; tpp_regs_out out NUM_REGS*REG_WIDTH register state.
REQ-013 SHALL have ports: s_axis_tdata/tstrb/tuser/tvalid/tlast in, s_axis_tready out; m_axis_tdata/tstrb/tuser/tvalid/tlast out, m_axis_tready in; AXI4-Stream.
REQ-014 SHALL have port: cas_fail_count out 32 count of failed compare-and-swap instructions.

Function
REQ-015 SHALL buffer input in a fall-through FIFO; s_axis_tready = not nearly_full; beat accepted cycle N visible on m_axis cycle N+1.
REQ-016 SHALL drive m_axis_tvalid = FIFO not empty; pop only on tvalid&tready; tdata/tstrb/tuser/tlast pass unchanged except as REQ-021/023.
REQ-017 SHALL track beat index per packet with an 8-bit saturating counter cleared after any tlast handshake.
REQ-018 SHALL use states HDR (beat<INS_BEAT), INS, EXEC, PASS; tlast handshake in any state -> HDR.
REQ-019 In INS, on handshake, SHALL latch opcode=slot[7:0], addr=slot[15:8] mod NUM_REGS, imm=slot[31:16]; -> EXEC if opcode in {0,2,4}, else PASS.
REQ-020 INS beat with tlast SHALL execute nothing.
REQ-021 LOAD (0): SHALL replace hop-memory slot on output with register[addr] current value.
REQ-022 STORE (2): SHALL write register[addr] <= hop-memory slot on the EXEC handshake only.
REQ-023 CAS (4): if register[addr][15:0]==imm, register <= slot and output slot <= old register value; else both unchanged and cas_fail_count += 1 (wraps at 2^32).
REQ-024 EXEC -> PASS on non-last handshake; stall (tvalid&!tready) SHALL hold state and apply no register write.
REQ-025 Registers with permission bit 0 SHALL load tpp_regs_in every cycle; STORE/CAS writes to them ignored, CAS output then uses current value, compare still counted.
REQ-026 Packets shorter than INS_BEAT+2 beats SHALL pass unmodified.

Reset
REQ-027 While axi_reset high: state=HDR, beat=0, registers=REG_DEFAULT, cas_fail_count=0, FIFO emptied, m_axis_tvalid=0.
REQ-028 Reset mid-packet SHALL discard buffered beats; next accepted beat is beat 0.

Structure
REQ-029 Opcode values, state encoding and slot field offsets SHALL live in shared package tpp_pkg.
REQ-030 Input buffer SHALL be sub-module fallthrough_small_fifo; no other sub-modules.

Verification
REQ-031 LOAD: reg3=0x1122334455667788, 5-beat packet, INS slot opcode 0 addr 3 -> beat 3 slot = 0x1122334455667788, other bits unchanged.
REQ-032 STORE: opcode 2 addr 5, hop slot 0xDEADBEEF00000001 -> tpp_regs_out reg5 equals it one cycle after beat-3 handshake.
REQ-033 CAS: reg1[15:0]=0x00AA, imm 0x00AA -> swap; imm 0x00AB -> no change, cas_fail_count=1.
REQ-034 Backpressure: m_axis_tready toggled 50% random over 100 packets -> output beat-exact to input, no register change on stalled cycles.
REQ-035 Permission 0 on reg2, STORE to reg2 -> reg2 tracks tpp_regs_in; 3-beat packet with tlast on INS beat -> no execution.
REQ-036 Reset asserted on beat 2 -> outputs/registers at defaults, following packet processed correctly.
